// File: rtl/gear_shift_sequencer.sv
`default_nettype none
// ============================================================================
// gear_shift_sequencer : debounced manual/brake/auto gear-shift arbiter
// Rev 1.0
// ============================================================================
module gear_shift_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250,
  parameter int HOLDOFF_CYCLES  = 500,
  parameter int MAX_GEAR        = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_brake,
  input  logic       auto_mode,
  input  logic [3:0] speed,
  output logic       shift_up_pulse,
  output logic       shift_down_pulse,
  output logic [2:0] gear,
  output logic       busy
);

  localparam int            DW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int            HW       = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HO_LAST  = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [2:0]    GEAR_MAX = 3'(MAX_GEAR);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PULSE   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  // Bit order for all per-button vectors: {brake, down, up}
  logic [2:0] btn_raw;
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0] deb_q, deb_d, deb_prev_q, deb_prev_d;

  assign btn_raw = {btn_brake, btn_down, btn_up};

  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
  end

  for (genvar i = 0; i < 3; i++) begin : g_debounce
    logic [DW-1:0] cnt_q, cnt_d;
    logic          deb_bit_d;

    // Counter only runs while the synchronized level disagrees with the output.
    always_comb begin
      cnt_d     = '0;
      deb_bit_d = deb_q[i];
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q == DB_LAST) begin
          deb_bit_d = sync2_q[i];
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign deb_d[i] = deb_bit_d;
  end

  logic up_req, dn_req, brake_req;
  assign up_req    = deb_q[0] & ~deb_prev_q[0];
  assign dn_req    = deb_q[1] & ~deb_prev_q[1];
  assign brake_req = deb_q[2];

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] ho_cnt_q, ho_cnt_d;
  logic [2:0]    gear_q, gear_d;
  logic          up_pulse_q, up_pulse_d, dn_pulse_q, dn_pulse_d;
  logic          busy_q, busy_d;

  logic       want_up, want_dn;
  logic [4:0] gear5, speed5, up_thr, dn_thr;

  always_comb begin
    want_up = 1'b0;
    want_dn = 1'b0;
    gear5   = {2'b00, gear_q};
    speed5  = {1'b0, speed};
    up_thr  = gear5 * 5'd3;
    dn_thr  = (gear5 - 5'd1) * 5'd3;
    if (brake_req) begin
      want_dn = (gear_q > 3'd1);
    end else if (!auto_mode) begin
      if (up_req ^ dn_req) begin
        want_up = up_req && (gear_q < GEAR_MAX);
        want_dn = dn_req && (gear_q > 3'd1);
      end
    end else begin
      want_up = (gear_q < GEAR_MAX) && (speed5 >= up_thr);
      want_dn = (gear_q > 3'd1) && (speed5 < dn_thr);
    end
  end

  always_comb begin
    state_d  = state_q;
    ho_cnt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (want_up || want_dn) begin
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (ho_cnt_q == HO_LAST) begin
          state_d = ST_IDLE;
        end else begin
          ho_cnt_d = ho_cnt_q + HW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    up_pulse_d = 1'b0;
    dn_pulse_d = 1'b0;
    gear_d     = gear_q;
    if (state_q == ST_IDLE) begin
      if (want_up) begin
        up_pulse_d = 1'b1;
        gear_d     = gear_q + 3'd1;
      end else if (want_dn) begin
        dn_pulse_d = 1'b1;
        gear_d     = gear_q - 3'd1;
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      state_q    <= ST_IDLE;
      ho_cnt_q   <= '0;
      gear_q     <= 3'd1;
      up_pulse_q <= 1'b0;
      dn_pulse_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      state_q    <= state_d;
      ho_cnt_q   <= ho_cnt_d;
      gear_q     <= gear_d;
      up_pulse_q <= up_pulse_d;
      dn_pulse_q <= dn_pulse_d;
      busy_q     <= busy_d;
    end
  end

  assign shift_up_pulse   = up_pulse_q;
  assign shift_down_pulse = dn_pulse_q;
  assign gear             = gear_q;
  assign busy             = busy_q;

endmodule
`default_nettype wire
